// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types and sizing for the TPU run sequencer
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WLOAD = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } tpu_state_e;

  localparam int ROWS_W          = 7;
  localparam int DEF_PIPE_LAT    = 128;
  localparam int DEF_MATRIX_SIZE = 64;

  // Counter must reach PIPE_LAT+MATRIX_SIZE-1 in RUN; one extra value of headroom.
  function automatic int cnt_width(input int pipe_lat, input int matrix_size);
    return $clog2(pipe_lat + matrix_size + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_PIPE_LAT, DEF_MATRIX_SIZE);

endpackage

// File: rtl/tpu_run_counter.sv
// rtl/tpu_run_counter.sv - loadable up-counter with clear and enable, shared by WLOAD and RUN
module tpu_run_counter
  import tpu_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_nxt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/tpu_run_sequencer.sv
// rtl/tpu_run_sequencer.sv - start/done sequencer for one weight-load + matmul pass
module tpu_run_sequencer
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE  = 10,
  parameter int FIFO_ADDR_W  = 2,
  parameter int MATRIX_SIZE  = 64,
  parameter int WLOAD_CYCLES = 2,
  parameter int PIPE_LAT     = 128
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] cfg_ub_base,
  input  logic [ADDRESSSIZE-1:0] cfg_res_base,
  input  logic [ROWS_W-1:0]      cfg_num_rows,
  input  logic [FIFO_ADDR_W-1:0] cfg_wslot,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ub_rd_en,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic [FIFO_ADDR_W-1:0] fifo_addr,
  output logic                   we_rl,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr
);

  localparam int              CW         = cnt_width(PIPE_LAT, MATRIX_SIZE);
  localparam logic [CW-1:0]   WLOAD_LAST = CW'(WLOAD_CYCLES - 1);
  localparam logic [CW-1:0]   PIPE_LAT_C = CW'(PIPE_LAT);

  tpu_state_e             state_q, state_d;
  logic [ADDRESSSIZE-1:0] ub_base_q, ub_base_d, res_base_q, res_base_d;
  logic [ROWS_W-1:0]      rows_q, rows_d;
  logic [FIFO_ADDR_W-1:0] wslot_q, wslot_d;
  logic [CW-1:0]          cnt_q, cnt_d, rows_c, run_last;
  logic                   cnt_clr, cnt_en, rows_ok;

  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                   ub_rd_en_q, ub_rd_en_d, we_rl_q, we_rl_d, res_we_q, res_we_d;
  logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d, res_addr_q, res_addr_d;
  logic [FIFO_ADDR_W-1:0] fifo_addr_q, fifo_addr_d;

  assign rows_ok  = (cfg_num_rows != '0) && (int'(cfg_num_rows) <= MATRIX_SIZE);
  assign rows_c   = CW'(rows_q);
  assign run_last = PIPE_LAT_C + rows_c - CW'(1);

  tpu_run_counter #(.W(CW)) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .clr_i      (cnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (cnt_en),
    .cnt_o      (cnt_q),
    .cnt_nxt_o  (cnt_d)
  );

  always_comb begin
    state_d    = state_q;
    ub_base_d  = ub_base_q;
    res_base_d = res_base_q;
    rows_d     = rows_q;
    wslot_d    = wslot_q;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && rows_ok) begin
          state_d    = WLOAD;
          ub_base_d  = cfg_ub_base;
          res_base_d = cfg_res_base;
          rows_d     = cfg_num_rows;
          wslot_d    = cfg_wslot;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      WLOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          err_d = start;
          if (cnt_q == WLOAD_LAST) begin
            state_d = RUN;
          end else begin
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          err_d = start;
          if (cnt_q == run_last) begin
            state_d = DONE;
          end else begin
            cnt_clr = 1'b0;
            cnt_en  = 1'b1;
          end
        end
      end
      default: begin
        err_d   = start;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state cycle.
  always_comb begin
    busy_d      = (state_d == WLOAD) || (state_d == RUN);
    done_d      = (state_d == DONE);
    we_rl_d     = (state_d == WLOAD) && (cnt_d == WLOAD_LAST);
    fifo_addr_d = (state_d == WLOAD) ? wslot_d : fifo_addr_q;
    ub_rd_en_d  = (state_d == RUN) && (cnt_d < rows_c);
    ub_addr_d   = ub_rd_en_d ? ub_base_q + ADDRESSSIZE'(cnt_d) : ub_addr_q;
    res_we_d    = (state_d == RUN) && (cnt_d >= PIPE_LAT_C) && (cnt_d < PIPE_LAT_C + rows_c);
    res_addr_d  = res_we_d ? res_base_q + ADDRESSSIZE'(cnt_d - PIPE_LAT_C) : res_addr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ub_base_q   <= '0;
      res_base_q  <= '0;
      rows_q      <= '0;
      wslot_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ub_rd_en_q  <= 1'b0;
      we_rl_q     <= 1'b0;
      res_we_q    <= 1'b0;
      ub_addr_q   <= '0;
      res_addr_q  <= '0;
      fifo_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      ub_base_q   <= ub_base_d;
      res_base_q  <= res_base_d;
      rows_q      <= rows_d;
      wslot_q     <= wslot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ub_rd_en_q  <= ub_rd_en_d;
      we_rl_q     <= we_rl_d;
      res_we_q    <= res_we_d;
      ub_addr_q   <= ub_addr_d;
      res_addr_q  <= res_addr_d;
      fifo_addr_q <= fifo_addr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ub_rd_en  = ub_rd_en_q;
  assign ub_addr   = ub_addr_q;
  assign fifo_addr = fifo_addr_q;
  assign we_rl     = we_rl_q;
  assign res_we    = res_we_q;
  assign res_addr  = res_addr_q;

endmodule

// File: tb/tb_tpu_run_sequencer.sv
// tb/tb_tpu_run_sequencer.sv - directed table-driven bench for tpu_run_sequencer
module tb_tpu_run_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0, start2 = 1'b0, abort = 1'b0;
  logic [9:0] cfg_ub_base = '0, cfg_res_base = '0;
  logic [6:0] cfg_num_rows = '0;
  logic [1:0] cfg_wslot = '0;

  logic       busy, done, err, ub_rd_en, we_rl, res_we;
  logic [9:0] ub_addr, res_addr;
  logic [1:0] fifo_addr;
  logic       p_busy, p_done, p_err, p_ub_rd_en, p_we_rl, p_res_we;
  logic [9:0] p_ub_addr, p_res_addr;
  logic [1:0] p_fifo_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tpu_run_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_ub_base(cfg_ub_base), .cfg_res_base(cfg_res_base),
    .cfg_num_rows(cfg_num_rows), .cfg_wslot(cfg_wslot),
    .busy(busy), .done(done), .err(err), .ub_rd_en(ub_rd_en), .ub_addr(ub_addr),
    .fifo_addr(fifo_addr), .we_rl(we_rl), .res_we(res_we), .res_addr(res_addr)
  );

  tpu_run_sequencer #(.PIPE_LAT(4)) dut_p4 (
    .clk(clk), .rstn(rstn), .start(start2), .abort(1'b0),
    .cfg_ub_base(cfg_ub_base), .cfg_res_base(cfg_res_base),
    .cfg_num_rows(cfg_num_rows), .cfg_wslot(cfg_wslot),
    .busy(p_busy), .done(p_done), .err(p_err), .ub_rd_en(p_ub_rd_en), .ub_addr(p_ub_addr),
    .fifo_addr(p_fifo_addr), .we_rl(p_we_rl), .res_we(p_res_we), .res_addr(p_res_addr)
  );

  typedef struct {
    logic [6:0] n;
    logic [9:0] ub;
    logic [9:0] res;
    logic [1:0] ws;
    bit         e_err;
    int         e_rd;
    logic [9:0] e_fub;
    logic [9:0] e_lub;
    int         e_wr;
    logic [9:0] e_fres;
    logic [9:0] e_lres;
    int         e_done;
  } vec_t;

  vec_t vecs[6];

  int         st_rd_cnt, st_ub_bad, st_first_rd, st_wr_cnt, st_res_bad, st_first_wr;
  int         st_done, st_we_cnt, st_we_cyc, st_err_cyc;
  bit         st_busy_seen;
  logic [9:0] st_first_ub, st_last_ub, st_first_res, st_last_res;
  logic [1:0] st_we_fifo;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pulses start in the current cycle, then records what the main DUT does in cycles 1..max_cyc.
  task automatic observe(input int max_cyc, input int inj_cyc, input bit inj_abort,
                         input logic [9:0] ub_b, input logic [9:0] res_b);
    st_rd_cnt = 0; st_ub_bad = 0; st_first_rd = -1; st_wr_cnt = 0; st_res_bad = 0;
    st_first_wr = -1; st_done = -1; st_we_cnt = 0; st_we_cyc = -1; st_err_cyc = -1;
    st_busy_seen = 1'b0; st_first_ub = '0; st_last_ub = '0; st_first_res = '0;
    st_last_res = '0; st_we_fifo = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= max_cyc; k++) begin
      if (ub_rd_en) begin
        if (st_rd_cnt == 0) begin st_first_ub = ub_addr; st_first_rd = k; end
        if (ub_addr !== ub_b + 10'(st_rd_cnt)) st_ub_bad++;
        st_last_ub = ub_addr;
        st_rd_cnt++;
      end
      if (res_we) begin
        if (st_wr_cnt == 0) begin st_first_res = res_addr; st_first_wr = k; end
        if (res_addr !== res_b + 10'(st_wr_cnt)) st_res_bad++;
        st_last_res = res_addr;
        st_wr_cnt++;
      end
      if (we_rl) begin
        st_we_cnt++;
        if (st_we_cyc < 0) begin st_we_cyc = k; st_we_fifo = fifo_addr; end
      end
      if (err && st_err_cyc < 0) st_err_cyc = k;
      if (busy) st_busy_seen = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      if (k == inj_cyc) begin
        if (inj_abort) begin
          abort = 1'b1;
        end else begin
          start = 1'b1;
          cfg_num_rows = 7'd64; cfg_ub_base = 10'h200; cfg_res_base = 10'h2AA; cfg_wslot = 2'd3;
        end
      end
      if (done) begin st_done = k; break; end
      if (k == max_cyc) break;
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic set_cfg(input vec_t v);
    cfg_num_rows = v.n; cfg_ub_base = v.ub; cfg_res_base = v.res; cfg_wslot = v.ws;
  endtask

  initial begin
    int   c;
    int   cnt_res, cnt_busy, cnt_done;
    vec_t v;
    //            n      ub      res     ws err rd  fub     lub     wr  fres    lres    done
    vecs[0] = '{7'd64, 10'h000, 10'h100, 2'd2, 0, 64, 10'h000, 10'h03F, 64, 10'h100, 10'h13F, 195};
    vecs[1] = '{7'd0,  10'h000, 10'h000, 2'd0, 1, 0,  10'h000, 10'h000, 0,  10'h000, 10'h000, -1};
    vecs[2] = '{7'd65, 10'h000, 10'h000, 2'd1, 1, 0,  10'h000, 10'h000, 0,  10'h000, 10'h000, -1};
    vecs[3] = '{7'd1,  10'h3FF, 10'h3FF, 2'd1, 0, 1,  10'h3FF, 10'h3FF, 1,  10'h3FF, 10'h3FF, 132};
    vecs[4] = '{7'd2,  10'h3FF, 10'h3FF, 2'd0, 0, 2,  10'h3FF, 10'h000, 2,  10'h3FF, 10'h000, 133};
    vecs[5] = '{7'd3,  10'h3FE, 10'h010, 2'd3, 0, 3,  10'h3FE, 10'h000, 3,  10'h010, 10'h012, 134};

    #1 rstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {err, ub_rd_en, we_rl, res_we}, 0);
    chk("rst_addrs", {ub_addr, res_addr, fifo_addr}, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      set_cfg(v);
      observe(v.e_err ? 6 : 260, -1, 1'b0, v.ub, v.res);
      chk($sformatf("v%0d_err_cyc", i), st_err_cyc, v.e_err ? 1 : -1);
      chk($sformatf("v%0d_busy_seen", i), st_busy_seen, !v.e_err);
      chk($sformatf("v%0d_rd_cnt", i), st_rd_cnt, v.e_rd);
      chk($sformatf("v%0d_wr_cnt", i), st_wr_cnt, v.e_wr);
      chk($sformatf("v%0d_done_cyc", i), st_done, v.e_done);
      if (v.e_rd > 0) begin
        chk($sformatf("v%0d_first_ub", i), st_first_ub, v.e_fub);
        chk($sformatf("v%0d_last_ub", i), st_last_ub, v.e_lub);
        chk($sformatf("v%0d_ub_seq_bad", i), st_ub_bad, 0);
        chk($sformatf("v%0d_first_rd_cyc", i), st_first_rd, 3);
        chk($sformatf("v%0d_first_res", i), st_first_res, v.e_fres);
        chk($sformatf("v%0d_last_res", i), st_last_res, v.e_lres);
        chk($sformatf("v%0d_res_seq_bad", i), st_res_bad, 0);
        chk($sformatf("v%0d_first_wr_cyc", i), st_first_wr, 131);
        chk($sformatf("v%0d_we_cnt", i), st_we_cnt, 1);
        chk($sformatf("v%0d_we_cyc", i), st_we_cyc, 2);
        chk($sformatf("v%0d_we_fifo", i), st_we_fifo, v.ws);
        chk($sformatf("v%0d_busy_at_done", i), busy, 0);
      end
      tick();
    end
    chk("hold_ub_addr", ub_addr, 10'h000);
    chk("hold_res_addr", res_addr, 10'h012);
    chk("hold_fifo_addr", fifo_addr, 2'd3);

    // start arriving mid-RUN must be rejected without disturbing the pass
    cfg_num_rows = 7'd5; cfg_ub_base = 10'h020; cfg_res_base = 10'h040; cfg_wslot = 2'd1;
    observe(260, 10, 1'b0, 10'h020, 10'h040);
    chk("srun_err_cyc", st_err_cyc, 11);
    chk("srun_rd_cnt", st_rd_cnt, 5);
    chk("srun_ub_bad", st_ub_bad, 0);
    chk("srun_wr_cnt", st_wr_cnt, 5);
    chk("srun_res_bad", st_res_bad, 0);
    chk("srun_done_cyc", st_done, 136);
    tick();

    // abort at c=10, then restart two cycles after the abort cycle
    set_cfg(vecs[0]);
    observe(14, 13, 1'b1, 10'h000, 10'h100);
    chk("abort_rd_cnt", st_rd_cnt, 11);
    chk("abort_no_done", st_done, -1);
    chk("abort_idle", {busy, ub_rd_en, res_we, we_rl, done}, 0);
    tick();
    set_cfg(vecs[0]);
    observe(260, -1, 1'b0, 10'h000, 10'h100);
    chk("restart_rd_cnt", st_rd_cnt, 64);
    chk("restart_wr_cnt", st_wr_cnt, 64);
    chk("restart_seq_bad", st_ub_bad + st_res_bad, 0);
    chk("restart_first_res", st_first_res, 10'h100);
    chk("restart_done_cyc", st_done, 195);
    tick();

    // reset asserted mid-RUN at c=40
    set_cfg(vecs[0]);
    observe(43, -1, 1'b0, 10'h000, 10'h100);
    chk("mrst_rd_cnt", st_rd_cnt, 41);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_strobes", {busy, done, err, ub_rd_en, we_rl, res_we}, 0);
    chk("mrst_addrs", {ub_addr, res_addr, fifo_addr}, 0);
    tick(); tick();
    chk("mrst_held", {busy, ub_rd_en, res_we, ub_addr}, 0);
    rstn = 1'b1;
    cnt_res = 0; cnt_busy = 0; cnt_done = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (res_we) cnt_res++;
      if (busy) cnt_busy++;
      if (done) cnt_done++;
    end
    chk("mrst_no_res_we", cnt_res, 0);
    chk("mrst_no_busy", cnt_busy, 0);
    chk("mrst_no_done", cnt_done, 0);

    // PIPE_LAT=4 instance: read and write windows overlap on c=4..7
    cfg_num_rows = 7'd8; cfg_ub_base = 10'h050; cfg_res_base = 10'h300; cfg_wslot = 2'd1;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      c = k - 3;
      chk($sformatf("p4_rd_en_k%0d", k), p_ub_rd_en, (c >= 0 && c < 8));
      if (c >= 0 && c < 8) chk($sformatf("p4_ub_addr_k%0d", k), p_ub_addr, 10'h050 + 10'(c));
      chk($sformatf("p4_res_we_k%0d", k), p_res_we, (c >= 4 && c < 12));
      if (c >= 4 && c < 12) chk($sformatf("p4_res_addr_k%0d", k), p_res_addr, 10'h300 + 10'(c - 4));
      chk($sformatf("p4_done_k%0d", k), p_done, (k == 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tpu_run_sequencer.md
Name: tpu_run_sequencer

Overview:
Sequences one matrix-multiply pass of the TPU top: weight-slot select and reload, streaming of activation rows out of the unified buffer, then write-back of de-skewed result rows into the result SRAM. It replaces the free-running result counter and externally driven UB/FIFO addresses with a single start/done handshake. It sits between the host-side control interface and the UB, weight SRAM, systolic array and result SRAM ports.

Parameters:
ADDRESSSIZE, 10, UB and result SRAM address width
FIFO_ADDR_W, 2, weight-slot address width
MATRIX_SIZE, 64, maximum rows per pass (array dimension)
WLOAD_CYCLES, 2, cycles spent in weight load; we_rl fires on the last one (covers the weight SRAM read latency)
PIPE_LAT, 128, cycles from the first UB read issue to the first valid row at the result-reverser output

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
start  in  1  begin a pass; sampled only in IDLE
abort  in  1  synchronous abort of the current pass
cfg_ub_base  in  ADDRESSSIZE  first UB row address
cfg_res_base  in  ADDRESSSIZE  first result SRAM row address
cfg_num_rows  in  7  rows in this pass; legal range 1..MATRIX_SIZE
cfg_wslot  in  FIFO_ADDR_W  weight slot to load
busy  out  1  high in WLOAD and RUN
done  out  1  one-cycle pulse at pass completion
err  out  1  one-cycle pulse when a start is rejected
ub_rd_en  out  1  UB read strobe
ub_addr  out  ADDRESSSIZE  UB read address
fifo_addr  out  FIFO_ADDR_W  weight SRAM address
we_rl  out  1  weight reload pulse to the systolic array
res_we  out  1  result SRAM write enable
res_addr  out  ADDRESSSIZE  result SRAM write address

Behaviour:
- Reset (async, rstn=0): state IDLE; counter 0; every output 0; cfg registers 0.
- IDLE:
  - start=1 with 1<=cfg_num_rows<=MATRIX_SIZE: latch all cfg_* inputs; go to WLOAD next cycle.
  - Out-of-range cfg_num_rows: stay in IDLE; err=1 for one cycle.
- WLOAD:
  - Lasts WLOAD_CYCLES cycles; fifo_addr = latched wslot throughout.
  - we_rl=1 only in the final WLOAD cycle.
  - Then go to RUN with counter c=0.
- RUN, with counter c incrementing every cycle and N = latched num_rows:
  - ub_rd_en=1 and ub_addr = ub_base+c for 0<=c<N.
  - res_we=1 and res_addr = res_base+(c-PIPE_LAT) for PIPE_LAT<=c<PIPE_LAT+N.
  - Address sums are modulo 2^ADDRESSSIZE (wrap, no error).
  - If N > PIPE_LAT, the read and write windows overlap; both are driven in the same cycle.
  - At c = PIPE_LAT+N-1, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. The first start accepted is on the cycle after DONE.
- start while busy or in DONE: ignored, err=1 for one cycle; the current pass is unaffected.
- abort=1 in WLOAD or RUN: next cycle state is IDLE, all strobes 0, no done pulse. abort in IDLE or DONE has no effect. abort has priority over start in the same cycle.
- fifo_addr holds its last value outside WLOAD. ub_addr and res_addr hold their last value when their strobes are low.
- All outputs are registered (Moore). Latency from start to the first ub_rd_en is WLOAD_CYCLES+1 cycles.
- Reset during a pass: outputs go to 0 immediately; nothing is written after reset releases.

Decomposition:
- Shared package tpu_pkg:
  - state enum {IDLE, WLOAD, RUN, DONE};
  - CNT_W = $clog2(PIPE_LAT+MATRIX_SIZE+1);
  - row-count width constant (7).
- One sub-module, tpu_run_counter: a loadable up-counter with clear and enable of width CNT_W, reused for both the WLOAD and RUN phases.
- The address adders stay in the top FSM.

Test Plan:
- Reset mid-RUN (c=40): all outputs 0 while rstn=0; after release the block stays IDLE with no res_we.
- N=64, ub_base=0, res_base=0x100, wslot=2, default parameters:
  - we_rl high at cycle 2 after start, with fifo_addr=2;
  - ub_addr 0..63 on cycles 3..66;
  - res_addr 0x100..0x13F on cycles 131..194;
  - done at cycle 195.
- N=1, ub_base=0x3FF, res_base=0x3FF: exactly one UB read at 0x3FF and one result write at 0x3FF. Then N=3, ub_base=0x3FE: ub_addr sequence is 0x3FE, 0x3FF, 0x000 (wrap).
- start with cfg_num_rows=0, then with 65: err pulse each time, busy stays 0. start during RUN: err pulse, pass completes unchanged.
- PIPE_LAT=4, N=8: res_we and ub_rd_en are both high on c=4..7, with correct independent addresses.
- abort at c=10 of an N=64 pass: state IDLE next cycle, no done. A new start two cycles later runs a full, correct pass.
